next_pc_unit: RTL and testbench

- Parametrised next-PC resolver for the multi-cycle MIPS core. Handles sequential, J, JAL, JR, return and BEQ/BNE control flow.
- Adds a circular return-address stack (RAS) that predicts return targets and flags mispredictions.
- Sits between decode/ALU and the PC register. The controller starts it with a one-cycle request and waits for the `jump_done` pulse.
- PC is word-addressed: +1 per instruction.

---
 rtl/next_pc_unit.sv | 189 ++++++++++++++++++
 tb/tb_next_pc_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next-PC resolver for the multi-cycle MIPS core: SEQ/J/JAL/JR/RET/BEQ/BNE with a
// circular return-address stack that predicts return targets.
module next_pc_unit #(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [2:0]      i_mode,
   input  logic [PC_W-1:0] i_pc,
   input  logic [25:0]     i_addr,
   input  logic [15:0]     i_imm,
   input  logic [PC_W-1:0] i_reg_addr,
   input  logic            i_zero,
   output logic [PC_W-1:0] o_pc_out,
   output logic [PC_W-1:0] o_link_addr,
   output logic            o_link_we,
   output logic            o_taken,
   output logic            o_ras_hit,
   output logic            o_ras_ovf,
   output logic            o_ras_udf,
   output logic            o_illegal,
   output logic            o_busy,
   output logic            o_jump_done
);

   localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
   localparam logic [RAS_PTR_W:0] RAS_FULL = (RAS_PTR_W + 1)'(RAS_DEPTH);

   localparam logic [2:0] ModeSeq = 3'd0;
   localparam logic [2:0] ModeJ   = 3'd1;
   localparam logic [2:0] ModeJal = 3'd2;
   localparam logic [2:0] ModeJr  = 3'd3;
   localparam logic [2:0] ModeRet = 3'd4;
   localparam logic [2:0] ModeBeq = 3'd5;
   localparam logic [2:0] ModeBne = 3'd6;

   typedef enum logic [1:0] {StIdle, StResolve, StDone} state_e;

   state_e r_state, w_state_next;

   logic [2:0]      r_mode;
   logic [PC_W-1:0] r_pc, r_reg_addr;
   logic [25:0]     r_addr;
   logic [15:0]     r_imm;
   logic            r_zero;

   logic [PC_W-1:0] r_pc_out, r_link_addr;
   logic            r_link_we, r_taken, r_ras_hit, r_ras_ovf, r_ras_udf, r_illegal;

   logic [PC_W-1:0]    r_ras [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] r_ptr;
   logic [RAS_PTR_W:0]   r_cnt;

   logic [PC_W-1:0]      w_seq, w_br, w_jmp, w_target;
   logic [RAS_PTR_W-1:0] w_top_idx;
   logic w_taken, w_illegal, w_link_we, w_push, w_pop;
   logic w_empty, w_full, w_hit, w_ovf, w_udf;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:    if (i_en) w_state_next = StResolve;
         StResolve: w_state_next = StDone;
         StDone:    w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_seq     = r_pc + PC_W'(1);
      w_br      = w_seq + {{(PC_W - 16){r_imm[15]}}, r_imm};
      w_jmp     = {r_pc[PC_W-1:26], r_addr};
      w_top_idx = r_ptr - RAS_PTR_W'(1);
      w_empty   = (r_cnt == '0);
      w_full    = (r_cnt == RAS_FULL);
      w_target  = w_seq;
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      w_link_we = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      case (r_mode)
         ModeSeq: ;
         ModeJ: begin
            w_target = w_jmp;
            w_taken  = 1'b1;
         end
         ModeJal: begin
            w_target  = w_jmp;
            w_taken   = 1'b1;
            w_link_we = 1'b1;
            w_push    = 1'b1;
         end
         ModeJr: begin
            w_target = r_reg_addr;
            w_taken  = 1'b1;
         end
         ModeRet: begin
            w_target = r_reg_addr;
            w_taken  = 1'b1;
            w_pop    = 1'b1;
         end
         ModeBeq: if (r_zero) begin
            w_target = w_br;
            w_taken  = 1'b1;
         end
         ModeBne: if (!r_zero) begin
            w_target = w_br;
            w_taken  = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      // The architectural register always supplies the target; the RAS only grades it.
      w_hit = w_pop && !w_empty && (r_ras[w_top_idx] == r_reg_addr);
      w_ovf = w_push && w_full;
      w_udf = w_pop && w_empty;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_mode      <= '0;
         r_pc        <= '0;
         r_addr      <= '0;
         r_imm       <= '0;
         r_reg_addr  <= '0;
         r_zero      <= 1'b0;
         r_pc_out    <= '0;
         r_link_addr <= '0;
         r_link_we   <= 1'b0;
         r_taken     <= 1'b0;
         r_ras_hit   <= 1'b0;
         r_ras_ovf   <= 1'b0;
         r_ras_udf   <= 1'b0;
         r_illegal   <= 1'b0;
         r_ptr       <= '0;
         r_cnt       <= '0;
      end else begin
         r_state   <= w_state_next;
         r_link_we <= 1'b0;
         r_ras_ovf <= 1'b0;
         r_ras_udf <= 1'b0;
         if (r_state == StIdle && i_en) begin
            r_mode     <= i_mode;
            r_pc       <= i_pc;
            r_addr     <= i_addr;
            r_imm      <= i_imm;
            r_reg_addr <= i_reg_addr;
            r_zero     <= i_zero;
         end
         if (r_state == StResolve) begin
            r_pc_out    <= w_target;
            r_link_addr <= w_seq;
            r_link_we   <= w_link_we;
            r_taken     <= w_taken;
            r_ras_hit   <= w_hit;
            r_ras_ovf   <= w_ovf;
            r_ras_udf   <= w_udf;
            r_illegal   <= w_illegal;
            if (w_push) begin
               r_ptr <= r_ptr + RAS_PTR_W'(1);
               if (!w_full) r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_empty) begin
               r_ptr <= w_top_idx;
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   // Stack contents need no reset; the write is gated so an aborting reset leaves it intact.
   always_ff @(posedge i_clk) begin
      if (!i_rst && r_state == StResolve && w_push) r_ras[r_ptr] <= w_seq;
   end

   assign o_pc_out    = r_pc_out;
   assign o_link_addr = r_link_addr;
   assign o_link_we   = r_link_we;
   assign o_taken     = r_taken;
   assign o_ras_hit   = r_ras_hit;
   assign o_ras_ovf   = r_ras_ovf;
   assign o_ras_udf   = r_ras_udf;
   assign o_illegal   = r_illegal;
   assign o_busy      = (r_state != StIdle);
   assign o_jump_done = (r_state == StDone);

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: vector table for per-mode results and RAS behaviour,
// plus hand sequences for reset abort and en-while-busy.
module tb_next_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [2:0]  mode = '0;
   logic [31:0] pc = '0;
   logic [25:0] addr = '0;
   logic [15:0] imm = '0;
   logic [31:0] reg_addr = '0;
   logic        zero = 1'b0;
   logic [31:0] pc_out, link_addr;
   logic        link_we, taken, ras_hit, ras_ovf, ras_udf, illegal, busy, jump_done;

   int n_tests = 0;
   int n_fail  = 0;

   next_pc_unit #(.PC_W(32), .RAS_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_pc(pc), .i_addr(addr),
      .i_imm(imm), .i_reg_addr(reg_addr), .i_zero(zero), .o_pc_out(pc_out),
      .o_link_addr(link_addr), .o_link_we(link_we), .o_taken(taken), .o_ras_hit(ras_hit),
      .o_ras_ovf(ras_ovf), .o_ras_udf(ras_udf), .o_illegal(illegal), .o_busy(busy),
      .o_jump_done(jump_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  mode;
      logic [31:0] pc;
      logic [25:0] addr;
      logic [15:0] imm;
      logic [31:0] ra;
      logic        zero;
      logic [31:0] e_pc;
      logic [31:0] e_link;
      logic        e_tk, e_hit, e_ill, e_lwe, e_ovf, e_udf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] m, input logic [31:0] p, input logic [25:0] a,
                               input logic [15:0] im, input logic [31:0] r, input logic z,
                               input logic [31:0] epc, input logic tk, input logic hit,
                               input logic ill, input logic lwe, input logic ovf,
                               input logic udf);
      vec_t v;
      v.mode = m; v.pc = p; v.addr = a; v.imm = im; v.ra = r; v.zero = z;
      v.e_pc = epc; v.e_link = p + 32'd1;
      v.e_tk = tk; v.e_hit = hit; v.e_ill = ill; v.e_lwe = lwe; v.e_ovf = ovf; v.e_udf = udf;
      return v;
   endfunction

   // Issue one request from IDLE and check latency, DONE outputs and post-DONE behaviour.
   task automatic run_vec(input int idx, input vec_t v);
      string t;
      t = $sformatf("v%0d", idx);
      @(negedge clk);
      en = 1'b1; mode = v.mode; pc = v.pc; addr = v.addr; imm = v.imm;
      reg_addr = v.ra; zero = v.zero;
      @(negedge clk);
      en = 1'b0;
      chk({t, " resolve busy"}, {31'd0, busy}, 32'd1);
      chk({t, " resolve done"}, {31'd0, jump_done}, 32'd0);
      @(negedge clk);
      chk({t, " done"}, {31'd0, jump_done}, 32'd1);
      chk({t, " pc_out"}, pc_out, v.e_pc);
      chk({t, " link_addr"}, link_addr, v.e_link);
      chk({t, " flags tk/hit/ill/lwe/ovf/udf"},
          {26'd0, taken, ras_hit, illegal, link_we, ras_ovf, ras_udf},
          {26'd0, v.e_tk, v.e_hit, v.e_ill, v.e_lwe, v.e_ovf, v.e_udf});
      @(negedge clk);
      chk({t, " idle busy/done/pulses"},
          {27'd0, busy, jump_done, link_we, ras_ovf, ras_udf}, 32'd0);
      chk({t, " pc_out held"}, pc_out, v.e_pc);
   endtask

   initial begin
      // Table order matters: the RAS carries state from one vector to the next.
      vecs.push_back(mk(3'd1, 32'h0400_0010, 26'h123, 16'h0, 32'h0, 1'b0,
                        32'h0400_0123, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd2, 32'h40, 26'h55, 16'h0, 32'h0, 1'b0, 32'h55, 1, 0, 0, 1, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h41, 1'b0, 32'h41, 1, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(3'd2, 32'(i * 16), 26'h0, 16'h0, 32'h0, 1'b0, 32'h0,
                           1, 0, 0, 1, (i == 5), 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h51, 1'b0, 32'h51, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h41, 1'b0, 32'h41, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h31, 1'b0, 32'h31, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h21, 1'b0, 32'h21, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h11, 1'b0, 32'h11, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(3'd5, 32'h100, 26'h0, 16'hFFFE, 32'h0, 1'b1, 32'hFF, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd6, 32'h100, 26'h0, 16'hFFFE, 32'h0, 1'b1, 32'h101, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd0, 32'hFFFF_FFFF, 26'h0, 16'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd7, 32'h200, 26'h0, 16'h0, 32'h0, 1'b0, 32'h201, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(3'd3, 32'h300, 26'h0, 16'h0, 32'h1234_5678, 1'b0, 32'h1234_5678,
                        1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h5, 1'b0, 32'h5, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(3'd5, 32'h100, 26'h0, 16'h0010, 32'h0, 1'b0, 32'h101, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd6, 32'h10, 26'h0, 16'h7FFF, 32'h0, 1'b0, 32'h8010, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3'd2, 32'hFC00_0007, 26'h3FF_FFFF, 16'h0, 32'h0, 1'b0, 32'hFFFF_FFFF,
                        1, 0, 0, 1, 0, 0));

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("reset outputs",
          {22'd0, link_we, taken, ras_hit, ras_ovf, ras_udf, illegal, busy, jump_done, 2'd0},
          32'd0);
      chk("reset pc_out", pc_out, 32'd0);
      chk("reset link_addr", link_addr, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // JAL aborted by reset during RESOLVE: no completion, outputs cleared, RAS cleared.
      @(negedge clk);
      en = 1'b1; mode = 3'd2; pc = 32'h60; addr = 26'h77;
      @(negedge clk);
      en = 1'b0;
      chk("abort in resolve", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort pc_out", pc_out, 32'd0);
      chk("abort link_addr", link_addr, 32'd0);
      chk("abort flags", {24'd0, link_we, taken, ras_hit, ras_ovf, ras_udf, illegal, busy,
                          jump_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (jump_done || busy) seen++;
         end
         chk("abort no jump_done", 32'(seen), 32'd0);
      end
      run_vec(100, mk(3'd4, 32'h0, 26'h0, 16'h0, 32'h61, 1'b0, 32'h61, 1, 0, 0, 0, 0, 1));

      // en held high while busy with different inputs must not disturb or re-trigger.
      @(negedge clk);
      en = 1'b1; mode = 3'd1; pc = 32'h0800_0000; addr = 26'h42;
      @(negedge clk);
      mode = 3'd0; pc = 32'h9; addr = 26'h0;
      @(negedge clk);
      chk("busy-en done", {31'd0, jump_done}, 32'd1);
      chk("busy-en pc_out", pc_out, 32'h0800_0042);
      en = 1'b0;
      @(negedge clk);
      chk("busy-en ignored", {30'd0, busy, jump_done}, 32'd0);
      @(negedge clk);
      chk("busy-en still idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
